// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and index/word types for the CPU register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

   localparam int c_DEF_DATA_W = 8;
   localparam int c_DEF_ADDR_W = 3;

   typedef logic [c_DEF_DATA_W-1:0] word_t;
   typedef logic [c_DEF_ADDR_W-1:0] ridx_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/cpu_regfile_rdport.sv
// ============================================================================
// Module      : cpu_regfile_rdport
// Description : One registered read port: index decode, R0 mask, write bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile_rdport
   import cpu_pkg::*;
#(
   parameter int DATA_W  = c_DEF_DATA_W,
   parameter int ADDR_W  = c_DEF_ADDR_W,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             i_rd_en,
   input  logic [ADDR_W-1:0]                i_rd_addr,
   input  logic [(2**ADDR_W)*DATA_W-1:0]    i_regs,
   input  logic [(2**ADDR_W)-1:0]           i_pend,
   input  logic                             i_wr_en,
   input  logic [ADDR_W-1:0]                i_waddr,
   input  logic [DATA_W-1:0]                i_wdata,
   output logic [DATA_W-1:0]                o_rd_data,
   output logic                             o_rd_valid,
   output logic                             o_rd_busy
);

   localparam logic [ADDR_W-1:0] c_R0 = '0;

   logic              w_is_r0;
   logic              w_hit;
   logic [DATA_W-1:0] w_next;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;

   assign w_is_r0 = (ZERO_R0 != 0) && (i_rd_addr == c_R0);
   assign w_hit   = (BYPASS != 0) && i_wr_en && (i_waddr == i_rd_addr);

   // Hardwired zero outranks bypass so R0 can never forward a write.
   always_comb begin
      w_next = '0;
      if (w_is_r0) begin
         w_next = '0;
      end else if (w_hit) begin
         w_next = i_wdata;
      end else begin
         w_next = i_regs[i_rd_addr*DATA_W +: DATA_W];
      end
   end

   assign o_rd_busy = i_pend[i_rd_addr] && !w_is_r0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            r_rd_data <= w_next;
         end
      end
   end

   assign o_rd_data  = r_rd_data;
   assign o_rd_valid = r_rd_valid;

endmodule : cpu_regfile_rdport

`default_nettype wire

// File: rtl/cpu_regfile.sv
// ============================================================================
// Module      : cpu_regfile
// Description : Multi-read-port register file with write bypass and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W  = c_DEF_DATA_W,
   parameter int ADDR_W  = c_DEF_ADDR_W,
   parameter int NUM_RD  = 2,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [NUM_RD-1:0]          rd_en,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_valid,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       claim,
   input  logic [ADDR_W-1:0]          caddr,
   output logic [(2**ADDR_W)-1:0]     pend_vec
);

   localparam int                c_DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_R0    = '0;

   logic [DATA_W-1:0]         r_regs [c_DEPTH];
   logic [c_DEPTH-1:0]        r_pend;
   logic [c_DEPTH-1:0]        w_pend_next;
   logic [c_DEPTH*DATA_W-1:0] w_regs_flat;
   logic                      w_wr_ok;
   logic                      w_claim_ok;

   assign w_wr_ok    = we    && !((ZERO_R0 != 0) && (waddr == c_R0));
   assign w_claim_ok = claim && !((ZERO_R0 != 0) && (caddr == c_R0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_regs[waddr] <= wdata;
      end
   end

   // Claim is applied after the write clear: a new producer keeps the entry pending.
   always_comb begin
      w_pend_next = r_pend;
      if (w_wr_ok) begin
         w_pend_next[waddr] = 1'b0;
      end
      if (w_claim_ok) begin
         w_pend_next[caddr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_next;
      end
   end

   assign pend_vec = r_pend;

   generate
      for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_flat
         assign w_regs_flat[gi*DATA_W +: DATA_W] = r_regs[gi];
      end

      for (genvar gp = 0; gp < NUM_RD; gp++) begin : g_rdport
         cpu_regfile_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
         ) u_rdport (
            .clk        (clk),
            .rst        (rst),
            .i_rd_en    (rd_en[gp]),
            .i_rd_addr  (rd_addr[gp*ADDR_W +: ADDR_W]),
            .i_regs     (w_regs_flat),
            .i_pend     (r_pend),
            .i_wr_en    (w_wr_ok),
            .i_waddr    (waddr),
            .i_wdata    (wdata),
            .o_rd_data  (rd_data[gp*DATA_W +: DATA_W]),
            .o_rd_valid (rd_valid[gp]),
            .o_rd_busy  (rd_busy[gp])
         );
      end
   endgenerate

endmodule : cpu_regfile

`default_nettype wire

// File: tb/tb_cpu_regfile.sv
// ============================================================================
// Module      : tb_cpu_regfile
// Description : Three configurations driven in lockstep against a register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_regfile;
   import cpu_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int NR    = 2;
   localparam int DEPTH = 8;
   localparam int NCFG  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   ridx_t             waddr;
   word_t             wdata;
   logic [NR-1:0]     rd_en;
   logic [NR*AW-1:0]  rd_addr;
   logic              claim;
   ridx_t             caddr;

   logic [NR*DW-1:0]  rd_data_a  [NCFG];
   logic [NR-1:0]     rd_valid_a [NCFG];
   logic [NR-1:0]     rd_busy_a  [NCFG];
   logic [DEPTH-1:0]  pend_a     [NCFG];

   // cfg0: bypass on; cfg1: bypass off; cfg2: hardwired R0 with bypass on
   logic [DW-1:0] m_mem  [NCFG][DEPTH];
   logic          m_pend [NCFG][DEPTH];
   logic [DW-1:0] m_rd   [NCFG][NR];
   logic          m_vld  [NCFG][NR];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cpu_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0), .BYPASS(1)) u_dut_byp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a[0]), .rd_valid(rd_valid_a[0]), .rd_busy(rd_busy_a[0]),
      .claim(claim), .caddr(caddr), .pend_vec(pend_a[0]));

   cpu_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0), .BYPASS(0)) u_dut_nobyp (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a[1]), .rd_valid(rd_valid_a[1]), .rd_busy(rd_busy_a[1]),
      .claim(claim), .caddr(caddr), .pend_vec(pend_a[1]));

   cpu_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1), .BYPASS(1)) u_dut_zr0 (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data_a[2]), .rd_valid(rd_valid_a[2]), .rd_busy(rd_busy_a[2]),
      .claim(claim), .caddr(caddr), .pend_vec(pend_a[2]));

   function automatic bit cfg_zr(input int c);
      return (c == 2);
   endfunction

   function automatic bit cfg_byp(input int c);
      return (c != 1);
   endfunction

   function automatic int raddr(input int p);
      return int'(rd_addr[p*AW +: AW]);
   endfunction

   task automatic chk(input string tag, input int c, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cfg%0d: got %0h expected %0h", tag, c, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCFG; c++) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[c][i]  = '0;
            m_pend[c][i] = 1'b0;
         end
         for (int p = 0; p < NR; p++) begin
            m_rd[c][p]  = '0;
            m_vld[c][p] = 1'b0;
         end
      end
   endtask

   task automatic model_step();
      for (int c = 0; c < NCFG; c++) begin
         bit wr_ok;
         wr_ok = we && !(cfg_zr(c) && waddr == 0);
         for (int p = 0; p < NR; p++) begin
            int a;
            a = raddr(p);
            if (rd_en[p]) begin
               if (cfg_zr(c) && a == 0)                      m_rd[c][p] = '0;
               else if (cfg_byp(c) && wr_ok && int'(waddr) == a) m_rd[c][p] = wdata;
               else                                          m_rd[c][p] = m_mem[c][a];
               m_vld[c][p] = 1'b1;
            end else begin
               m_vld[c][p] = 1'b0;
            end
         end
         if (wr_ok) begin
            m_mem[c][waddr]  = wdata;
            m_pend[c][waddr] = 1'b0;
         end
         if (claim && !(cfg_zr(c) && caddr == 0)) m_pend[c][caddr] = 1'b1;
      end
   endtask

   task automatic check_busy();
      for (int c = 0; c < NCFG; c++) begin
         for (int p = 0; p < NR; p++) begin
            int a;
            a = raddr(p);
            chk("rd_busy", c, 32'(rd_busy_a[c][p]), 32'(m_pend[c][a] && !(cfg_zr(c) && a == 0)));
         end
      end
   endtask

   task automatic check_outputs();
      for (int c = 0; c < NCFG; c++) begin
         logic [DEPTH-1:0] pv;
         for (int i = 0; i < DEPTH; i++) pv[i] = m_pend[c][i];
         chk("pend_vec", c, 32'(pend_a[c]), 32'(pv));
         for (int p = 0; p < NR; p++) begin
            chk("rd_data", c, 32'(rd_data_a[c][p*DW +: DW]), 32'(m_rd[c][p]));
            chk("rd_valid", c, 32'(rd_valid_a[c][p]), 32'(m_vld[c][p]));
         end
      end
   endtask

   // Inputs are driven just after a rising edge; one clock edge per call.
   task automatic cycle();
      #1;
      check_busy();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic drive(input logic i_we, input int i_wa, input int i_wd, input logic [NR-1:0] i_en,
                        input int i_a0, input int i_a1, input logic i_cl, input int i_ca);
      we      = i_we;
      waddr   = ridx_t'(i_wa);
      wdata   = word_t'(i_wd);
      rd_en   = i_en;
      rd_addr = {AW'(i_a1), AW'(i_a0)};
      claim   = i_cl;
      caddr   = ridx_t'(i_ca);
   endtask

   task automatic pulse_reset();
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs();
      rst = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] held;
      rst = 1'b0;
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      model_reset();
      #12;
      check_outputs();
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Reset mid-operation clears the written register and the scoreboard
      drive(1, 3, 8'hA5, 2'b00, 0, 0, 1, 4);
      cycle();
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
      pulse_reset();
      for (int c = 0; c < NCFG; c++) chk("reset_pend", c, 32'(pend_a[c]), 32'h0);
      drive(0, 0, 0, 2'b01, 3, 0, 0, 0);
      cycle();
      for (int c = 0; c < NCFG; c++) begin
         chk("reset_r3", c, 32'(rd_data_a[c][7:0]), 32'h00);
         chk("reset_r3_valid", c, 32'(rd_valid_a[c][0]), 32'h1);
      end

      // Write then read on both ports
      drive(1, 5, 8'h3C, 2'b00, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 2'b11, 5, 5, 0, 0);
      cycle();
      for (int c = 0; c < NCFG; c++) begin
         chk("wr_rd_p0", c, 32'(rd_data_a[c][7:0]), 32'h3C);
         chk("wr_rd_p1", c, 32'(rd_data_a[c][15:8]), 32'h3C);
      end

      // Same-cycle write and read of R2
      drive(1, 2, 8'h11, 2'b00, 0, 0, 0, 0);
      cycle();
      drive(1, 2, 8'h22, 2'b11, 2, 2, 0, 0);
      cycle();
      chk("bypass_on", 0, 32'(rd_data_a[0][7:0]), 32'h22);
      chk("bypass_off", 1, 32'(rd_data_a[1][7:0]), 32'h11);
      chk("bypass_off_p1", 1, 32'(rd_data_a[1][15:8]), 32'h11);
      chk("bypass_zr_cfg", 2, 32'(rd_data_a[2][15:8]), 32'h22);

      // R0 write and claim
      drive(1, 0, 8'hFF, 2'b00, 0, 0, 1, 0);
      cycle();
      drive(0, 0, 0, 2'b01, 0, 0, 0, 0);
      #1;
      chk("r0_busy_zr", 2, 32'(rd_busy_a[2][0]), 32'h0);
      chk("r0_busy_norm", 0, 32'(rd_busy_a[0][0]), 32'h1);
      cycle();
      chk("r0_read_zr", 2, 32'(rd_data_a[2][7:0]), 32'h00);
      chk("r0_pend_zr", 2, 32'(pend_a[2][0]), 32'h0);
      chk("r0_read_norm", 0, 32'(rd_data_a[0][7:0]), 32'hFF);

      // Scoreboard claim / clear / claim-wins
      drive(1, 0, 8'h00, 2'b00, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 2'b00, 0, 0, 1, 4);
      cycle();
      for (int c = 0; c < NCFG; c++) chk("claim_r4", c, 32'(pend_a[c]), 32'h10);
      drive(0, 0, 0, 2'b10, 0, 4, 0, 0);
      #1;
      for (int c = 0; c < NCFG; c++) chk("busy_r4", c, 32'(rd_busy_a[c][1]), 32'h1);
      cycle();
      drive(1, 4, 8'h7E, 2'b00, 0, 0, 0, 0);
      cycle();
      for (int c = 0; c < NCFG; c++) chk("clear_r4", c, 32'(pend_a[c]), 32'h00);
      drive(1, 4, 8'h7E, 2'b00, 0, 0, 1, 4);
      cycle();
      for (int c = 0; c < NCFG; c++) chk("claim_wins", c, 32'(pend_a[c]), 32'h10);
      drive(0, 0, 0, 2'b01, 4, 0, 0, 0);
      cycle();
      for (int c = 0; c < NCFG; c++) chk("r4_data", c, 32'(rd_data_a[c][7:0]), 32'h7E);

      // Port 1 holds while disabled and R1 changes
      drive(1, 1, 8'h5A, 2'b00, 0, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 2'b10, 0, 1, 0, 0);
      cycle();
      held = 8'h5A;
      for (int k = 0; k < 3; k++) begin
         drive(1, 1, 8'h60 + k, 2'b00, 0, 1, 0, 0);
         cycle();
         for (int c = 0; c < NCFG; c++) begin
            chk("hold_data", c, 32'(rd_data_a[c][15:8]), 32'(held));
            chk("hold_valid", c, 32'(rd_valid_a[c][1]), 32'h0);
         end
      end

      // Random traffic with occasional asynchronous reset
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, 255)),
               NR'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH-1)), int'($urandom_range(0, DEPTH-1)),
               1'($urandom_range(0, 3) == 0), int'($urandom_range(0, DEPTH-1)));
         if ($urandom_range(0, 49) == 0) pulse_reset();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_cpu_regfile

`default_nettype wire
